// File: rtl/vce_cram_ctrl.sv
// CPU / pixel-path arbiter for the 512x9 colour RAM: CPU register file,
// auto-incrementing address, read prefetch buffer and pixel palette lookup.
module vce_cram_ctrl (
   input  logic       clk,
   input  logic       reset_N,
   input  logic       cpu_cs_n,
   input  logic       cpu_wr_n,
   input  logic       cpu_rd_n,
   input  logic [2:0] cpu_a,
   input  logic [7:0] cpu_din,
   output logic [7:0] cpu_dout,
   output logic       cpu_busy,
   output logic [7:0] cr,
   input  logic       pix_req,
   input  logic [8:0] pix_idx,
   output logic       pix_valid,
   output logic [8:0] pix_color,
   output logic [8:0] cram_addr,
   output logic       cram_we,
   output logic [8:0] cram_wdata,
   input  logic [8:0] cram_rdata
);

   typedef enum logic [1:0] {IDLE, WRITE, FETCH, FETCH_WAIT} state_t;

   state_t     state, state_nx;
   logic       wr_q, rd_q;
   logic       wr_ev, rd_ev, addr_wr, rd_cap;
   logic [8:0] addr, addr_nx, addr_new;
   logic [8:0] wbuf, rdbuf, pix_hold;
   logic [7:0] data_lo;

   // Strobe edge detect: a held strobe yields a single event
   assign wr_ev   = ~cpu_cs_n & ~cpu_wr_n & ~wr_q;
   assign rd_ev   = ~cpu_cs_n & ~cpu_rd_n & ~rd_q & cpu_wr_n;
   assign addr_wr = wr_ev & ((cpu_a == 3'd2) | (cpu_a == 3'd3));

   always_comb begin
      addr_new = addr;
      if (cpu_a == 3'd2)
         addr_new[7:0] = cpu_din;
      else
         addr_new[8] = cpu_din[0];
   end

   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      cram_we  = 1'b0;
      rd_cap   = 1'b0;
      case (state)
         IDLE: begin
            if (addr_wr) begin
               addr_nx  = addr_new;
               state_nx = FETCH;
            end else if (wr_ev && cpu_a == 3'd5) begin
               state_nx = WRITE;
            end else if (rd_ev && cpu_a == 3'd5) begin
               addr_nx  = addr + 9'd1;
               state_nx = FETCH;
            end
         end
         WRITE: begin
            if (!pix_req) begin
               cram_we  = 1'b1;
               addr_nx  = addr + 9'd1;
               state_nx = FETCH;
            end
            if (addr_wr)
               addr_nx = addr_new;
         end
         FETCH: begin
            if (addr_wr)
               addr_nx = addr_new;
            else if (!pix_req)
               state_nx = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            // cram_rdata here belongs to the address issued last cycle
            if (addr_wr) begin
               addr_nx  = addr_new;
               state_nx = FETCH;
            end else begin
               rd_cap   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state     <= IDLE;
         addr      <= '0;
         cr        <= '0;
         data_lo   <= '0;
         wbuf      <= '0;
         rdbuf     <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         pix_valid <= 1'b0;
         pix_hold  <= '0;
      end else begin
         state     <= state_nx;
         addr      <= addr_nx;
         wr_q      <= ~cpu_cs_n & ~cpu_wr_n;
         rd_q      <= ~cpu_cs_n & ~cpu_rd_n;
         pix_valid <= pix_req;
         if (pix_valid)
            pix_hold <= cram_rdata;
         if (rd_cap)
            rdbuf <= cram_rdata;
         if (wr_ev && cpu_a == 3'd0)
            cr <= cpu_din;
         if (wr_ev && cpu_a == 3'd4)
            data_lo <= cpu_din;
         if (wr_ev && cpu_a == 3'd5 && state == IDLE)
            wbuf <= {cpu_din[0], data_lo};
      end
   end

   assign cram_addr  = pix_req ? pix_idx : addr;
   assign cram_wdata = wbuf;
   assign pix_color  = pix_valid ? cram_rdata : pix_hold;
   assign cpu_busy   = (state != IDLE);

   always_comb begin
      case (cpu_a)
         3'd4:    cpu_dout = rdbuf[7:0];
         3'd5:    cpu_dout = {7'h7F, rdbuf[8]};
         default: cpu_dout = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_vce_cram_ctrl.sv
// Scoreboard bench for vce_cram_ctrl: behavioural CRAM, register model and
// queues of expected CRAM writes, pixel colours and CPU read data.
module tb_vce_cram_ctrl;

   logic       clk = 1'b0;
   logic       reset_N = 1'b0;
   logic       cpu_cs_n = 1'b1, cpu_wr_n = 1'b1, cpu_rd_n = 1'b1;
   logic [2:0] cpu_a = '0;
   logic [7:0] cpu_din = '0;
   logic [7:0] cpu_dout, cr;
   logic       cpu_busy, pix_valid, cram_we;
   logic       pix_req = 1'b0;
   logic [8:0] pix_idx = '0;
   logic [8:0] pix_color, cram_addr, cram_wdata;
   logic [8:0] cram_rdata = '0;

   vce_cram_ctrl dut (
      .clk(clk), .reset_N(reset_N),
      .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n),
      .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .cpu_busy(cpu_busy), .cr(cr),
      .pix_req(pix_req), .pix_idx(pix_idx),
      .pix_valid(pix_valid), .pix_color(pix_color),
      .cram_addr(cram_addr), .cram_we(cram_we),
      .cram_wdata(cram_wdata), .cram_rdata(cram_rdata)
   );

   always #5 clk = ~clk;

   // CRAM with one-cycle read latency plus a backdoor preload port
   logic [8:0] mem [0:511];
   logic       bd_we = 1'b0;
   logic [8:0] bd_addr = '0, bd_data = '0;
   always @(posedge clk) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      else if (cram_we)
         mem[cram_addr] <= cram_wdata;
      cram_rdata <= mem[cram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state
   logic [8:0]  ref_mem [0:511];
   logic [8:0]  m_addr = '0, m_rdbuf = '0;
   logic [7:0]  m_lo = '0, m_cr = '0;
   logic [17:0] wq[$];
   logic [8:0]  pq[$];
   logic [7:0]  dq[$];
   int total = 0, bad = 0, wr_seen = 0, pix_cnt = 0;
   int pix_until = 0;
   bit pix_rand = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] dout_model(input logic [2:0] a);
      if (a == 3'd4) return m_rdbuf[7:0];
      if (a == 3'd5) return {7'h7F, m_rdbuf[8]};
      return 8'hFF;
   endfunction

   // Pixel requester: palette indices stay below 0x100, CPU writes above
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (cyc < pix_until || (pix_rand && $urandom_range(1, 0) == 1)) begin
            pix_idx = 9'($urandom_range(255, 0));
            pix_req = 1'b1;
            if (reset_N) pq.push_back(ref_mem[pix_idx]);
         end else begin
            pix_req = 1'b0;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (reset_N) begin
         chk("we_with_pix_req", int'(cram_we & pix_req), 0);
         if (cram_we) begin
            wr_seen++;
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else chk("cram_write", int'({cram_addr, cram_wdata}), int'(wq.pop_front()));
         end
         if (pix_valid) begin
            pix_cnt++;
            if (pq.size() == 0) chk("unexpected_pix_valid", 1, 0);
            else chk("pix_color", int'(pix_color), int'(pq.pop_front()));
         end
         if (dq.size() > 0) chk("cpu_dout", int'(cpu_dout), int'(dq.pop_front()));
      end
   end

   task automatic bd_write(input logic [8:0] a, input logic [8:0] d);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d, input int hold, input bit drop);
      @(posedge clk); #1;
      cpu_a = a; cpu_din = d; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      case (a)
         3'd0: m_cr = d;
         3'd2: begin m_addr[7:0] = d; m_rdbuf = ref_mem[m_addr]; end
         3'd3: begin m_addr[8] = d[0]; m_rdbuf = ref_mem[m_addr]; end
         3'd4: m_lo = d;
         3'd5: if (!drop) begin
            wq.push_back({m_addr, d[0], m_lo});
            ref_mem[m_addr] = {d[0], m_lo};
            m_addr = m_addr + 9'd1;
            m_rdbuf = ref_mem[m_addr];
         end
         default: ;
      endcase
      repeat (hold) @(posedge clk);
      #1;
      cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
   endtask

   task automatic cpu_rd(input logic [2:0] a, input int hold);
      @(posedge clk); #1;
      cpu_a = a; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
      dq.push_back(dout_model(a));
      if (a == 3'd5) begin
         m_addr = m_addr + 9'd1;
         m_rdbuf = ref_mem[m_addr];
      end
      repeat (hold) @(posedge clk);
      #1;
      cpu_cs_n = 1'b1; cpu_rd_n = 1'b1;
   endtask

   task automatic peek(input logic [2:0] a, input logic [7:0] exp);
      @(posedge clk); #1;
      cpu_a = a;
      dq.push_back(exp);
      @(negedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (cpu_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", int'(cpu_busy), 0);
   endtask

   task automatic set_addr(input logic [8:0] a);
      wait_idle();
      cpu_wr(3'd3, {7'd0, a[8]}, 1, 1'b0);
      cpu_wr(3'd2, a[7:0], 1, 1'b0);
      wait_idle();
   endtask

   initial begin
      int w0, p0, n;
      // Preload under reset
      for (int i = 0; i < 512; i++) begin
         @(posedge clk); #1;
         bd_we = 1'b1; bd_addr = 9'(i); bd_data = 9'($urandom_range(511, 0));
         ref_mem[i] = bd_data;
      end
      @(posedge clk); #1;
      bd_we = 1'b0;
      cpu_a = 3'd4; #1;
      chk("rst_busy", int'(cpu_busy), 0);
      chk("rst_cram_we", int'(cram_we), 0);
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_pix_color", int'(pix_color), 0);
      chk("rst_cr", int'(cr), 0);
      chk("rst_dout", int'(cpu_dout), 0);
      @(negedge clk) reset_N = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_prefetch_after_reset", int'(cpu_busy), 0);

      // Basic write, held strobe gives a single write
      cpu_wr(3'd2, 8'h10, 1, 1'b0);
      cpu_wr(3'd3, 8'h01, 1, 1'b0);
      cpu_wr(3'd4, 8'hA5, 1, 1'b0);
      wait_idle();
      w0 = wr_seen;
      cpu_wr(3'd5, 8'h01, 6, 1'b0);
      wait_idle();
      chk("basic_write_count", wr_seen - w0, 1);
      peek(3'd4, dout_model(3'd4));
      peek(3'd5, dout_model(3'd5));

      // Write blocked by a 20-cycle pixel burst
      set_addr(9'h120);
      w0 = wr_seen; p0 = pix_cnt;
      @(posedge clk); #1;
      pix_until = cyc + 20;
      cpu_wr(3'd4, 8'h5E, 1, 1'b0);
      cpu_wr(3'd5, 8'h01, 1, 1'b0);
      n = 0;
      @(negedge clk);
      while (pix_req && n < 40) begin
         chk("busy_during_burst", int'(cpu_busy), 1);
         chk("no_we_during_burst", int'(cram_we), 0);
         @(negedge clk);
         n++;
      end
      chk("write_on_first_free", int'(cram_we), 1);
      wait_idle();
      chk("burst_write_count", wr_seen - w0, 1);
      chk("burst_pix_pulses", pix_cnt - p0, 20);
      peek(3'd4, dout_model(3'd4));

      // Address wrap at 0x1FF
      bd_write(9'h1FF, 9'h155);
      bd_write(9'h000, 9'h0C3);
      set_addr(9'h1FF);
      cpu_rd(3'd4, 1);
      cpu_rd(3'd5, 2);
      wait_idle();
      peek(3'd4, dout_model(3'd4));
      peek(3'd5, dout_model(3'd5));

      // Second data-high write while blocked is dropped
      set_addr(9'h130);
      w0 = wr_seen;
      @(posedge clk); #1;
      pix_until = cyc + 10;
      cpu_wr(3'd4, 8'h11, 1, 1'b0);
      cpu_wr(3'd5, 8'h01, 1, 1'b0);
      cpu_wr(3'd5, 8'h00, 1, 1'b1);
      wait_idle();
      chk("dropped_write_count", wr_seen - w0, 1);
      peek(3'd4, dout_model(3'd4));
      peek(3'd5, dout_model(3'd5));

      // Address change during FETCH_WAIT must not load stale data
      bd_write(9'h1C0, 9'h033);
      bd_write(9'h1A0, 9'h0AA);
      bd_write(9'h1B0, 9'h055);
      set_addr(9'h1C0);
      cpu_wr(3'd2, 8'hA0, 1, 1'b0);
      cpu_wr(3'd2, 8'hB0, 1, 1'b0);
      peek(3'd4, 8'h33);
      wait_idle();
      peek(3'd4, dout_model(3'd4));

      // Reset while a write is pending
      cpu_wr(3'd0, 8'h5A, 1, 1'b0);
      @(negedge clk);
      chk("cr_value", int'(cr), int'(m_cr));
      set_addr(9'h140);
      @(posedge clk); #1;
      pix_until = cyc + 50;
      cpu_wr(3'd4, 8'h77, 1, 1'b0);
      cpu_wr(3'd5, 8'h01, 1, 1'b1);
      @(negedge clk);
      chk("pending_before_reset", int'(cpu_busy), 1);
      #2 reset_N = 1'b0;
      #1;
      chk("mid_rst_busy", int'(cpu_busy), 0);
      chk("mid_rst_cram_we", int'(cram_we), 0);
      chk("mid_rst_pix_valid", int'(pix_valid), 0);
      chk("mid_rst_pix_color", int'(pix_color), 0);
      chk("mid_rst_cr", int'(cr), 0);
      cpu_a = 3'd4; #1;
      chk("mid_rst_dout", int'(cpu_dout), 0);
      m_addr = '0; m_lo = '0; m_cr = '0; m_rdbuf = '0;
      pix_until = 0;
      repeat (3) @(posedge clk);
      pq.delete();
      @(negedge clk) reset_N = 1'b1;
      w0 = wr_seen;
      repeat (30) @(negedge clk);
      chk("no_write_after_reset", wr_seen - w0, 0);
      chk("idle_after_reset", int'(cpu_busy), 0);
      peek(3'd4, dout_model(3'd4));

      // Randomised traffic with random pixel requests
      pix_rand = 1'b1;
      for (int i = 0; i < 60; i++) begin
         int op, hold;
         logic [2:0] ra;
         op = $urandom_range(5, 0);
         hold = $urandom_range(3, 1);
         case (op)
            0: begin
               cpu_wr(3'd0, 8'($urandom), hold, 1'b0);
               @(negedge clk);
               chk("cr_random", int'(cr), int'(m_cr));
            end
            1: cpu_wr(3'd4, 8'($urandom), hold, 1'b0);
            2: begin
               if (m_addr < 9'h100 || m_addr > 9'h1F0)
                  set_addr(9'h100 + 9'($urandom_range(224, 0)));
               wait_idle();
               cpu_wr(3'd5, 8'($urandom), $urandom_range(6, 1), 1'b0);
            end
            3: begin
               wait_idle();
               ra = 3'($urandom_range(7, 0));
               cpu_rd(ra, hold);
            end
            4: set_addr(9'h100 + 9'($urandom_range(224, 0)));
            default: begin
               wait_idle();
               ra = 3'($urandom_range(7, 0));
               peek(ra, dout_model(ra));
            end
         endcase
      end
      pix_rand = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      peek(3'd4, dout_model(3'd4));
      chk("writes_outstanding", wq.size(), 0);
      chk("pixels_outstanding", pq.size(), 0);
      chk("reads_outstanding", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
